// File: rtl/muldiv_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | muldiv_unit: iterative 32-cycle multiply/divide unit (RV32M funct3 encoding) |
// | Optional MULDIV_EARLY_EN: single-cycle divide-by-zero / overflow results.    |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  flush,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [4:0]            rd_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [4:0]            rd_out
);

    localparam int                    W           = DATA_WIDTH;
    localparam logic [5:0]            c_last_iter = 6'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] c_min_int   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state, w_next_state;
    logic [2:0]   r_op;
    logic [W-1:0] r_a, r_b, r_mcand, r_hi, r_lo;
    logic [4:0]   r_rd;
    logic [5:0]   r_cnt;
    logic         r_neg_q, r_neg_r;

    logic         w_accept, w_early, w_last;
    logic         w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [W-1:0] w_early_res, w_hi_nx, w_lo_nx, w_quot, w_rem, w_final;
    logic [W:0]   w_sum, w_rshift, w_diff, w_spec_lat;
    logic [2*W-1:0] w_prod;

    // Returns {flag, value}: flag set for divide-by-zero or signed overflow.
    function automatic logic [DATA_WIDTH:0] special_res(input logic [2:0] f,
                                                        input logic [DATA_WIDTH-1:0] x,
                                                        input logic [DATA_WIDTH-1:0] y);
        logic [DATA_WIDTH:0] res;
        res = '0;
        if (f[2]) begin
            if (y == '0)
                res = {1'b1, (f[1] ? x : {DATA_WIDTH{1'b1}})};
            else if (!f[0] && x == c_min_int && y == '1)
                res = {1'b1, (f[1] ? {DATA_WIDTH{1'b0}} : c_min_int)};
        end
        return res;
    endfunction

    assign w_accept   = (r_state != S_CALC) && start && !flush;
    assign w_last     = (r_state == S_CALC) && (r_cnt == c_last_iter);
    assign w_a_signed = op[2] ? !op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
    assign w_b_signed = op[2] ? !op[0] : (op[1:0] == 2'b01);
    assign w_a_neg    = w_a_signed && a[W-1];
    assign w_b_neg    = w_b_signed && b[W-1];

`ifdef MULDIV_EARLY_EN
    logic [W:0] w_spec_in;
    assign w_spec_in   = special_res(op, a, b);
    assign w_early     = w_accept && w_spec_in[W];
    assign w_early_res = w_spec_in[W-1:0];
`else
    assign w_early     = 1'b0;
    assign w_early_res = '0;
`endif

    assign busy = (r_state == S_CALC);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start)
                        w_next_state = w_early ? S_DONE : S_CALC;
                    else
                        w_next_state = S_IDLE;
                end
                S_CALC: begin
                    if (w_last)
                        w_next_state = S_DONE;
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // r_hi/r_lo hold {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
        w_rshift = {r_hi, r_lo[W-1]};
        w_diff   = w_rshift - {1'b0, r_mcand};
        if (r_op[2]) begin
            if (!w_diff[W]) begin
                w_hi_nx = w_diff[W-1:0];
                w_lo_nx = {r_lo[W-2:0], 1'b1};
            end else begin
                w_hi_nx = w_rshift[W-1:0];
                w_lo_nx = {r_lo[W-2:0], 1'b0};
            end
        end else begin
            w_hi_nx = w_sum[W:1];
            w_lo_nx = {w_sum[0], r_lo[W-1:1]};
        end
        w_prod     = r_neg_q ? -{w_hi_nx, w_lo_nx} : {w_hi_nx, w_lo_nx};
        w_quot     = r_neg_q ? -w_lo_nx : w_lo_nx;
        w_rem      = r_neg_r ? -w_hi_nx : w_hi_nx;
        w_spec_lat = special_res(r_op, r_a, r_b);
        if (w_spec_lat[W]) begin
            w_final = w_spec_lat[W-1:0];
        end else begin
            case (r_op)
                3'b000:                 w_final = w_prod[W-1:0];
                3'b001, 3'b010, 3'b011: w_final = w_prod[2*W-1:W];
                3'b100, 3'b101:         w_final = w_quot;
                default:                w_final = w_rem;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_mcand <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
        end else if (w_accept) begin
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            r_rd    <= rd_in;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= w_a_neg ? -a : a;
            r_mcand <= w_b_neg ? -b : b;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (w_early) begin
                result <= w_early_res;
                rd_out <= rd_in;
            end
        end else if (busy && !flush) begin
            r_cnt <= r_cnt + 6'd1;
            r_hi  <= w_hi_nx;
            r_lo  <= w_lo_nx;
            if (w_last) begin
                result <= w_final;
                rd_out <= r_rd;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// Self-checking bench for muldiv_unit: directed vectors, randomized ops against
// an arithmetic reference model, start-while-busy, back-to-back, flush and reset.
module tb_muldiv_unit;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int          n_checks = 0, n_fail = 0;
    logic [31:0] exp_last = '0;
    logic [4:0]  exp_rd_last = '0;

`ifdef MULDIV_EARLY_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
        .a(a), .b(b), .rd_in(rd_in), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        int sx, sy;
        sx = x;
        sy = y;
        case (f)
            3'd0: begin p = longint'(sx) * longint'(sy); return p[31:0]; end
            3'd1: begin p = longint'(sx) * longint'(sy); return p[63:32]; end
            3'd2: begin p = longint'(sx) * longint'({32'b0, y}); return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sx / sy;
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                return x / y;
            end
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                return sx % sy;
            end
            default: begin
                if (y == 0) return x;
                return x % y;
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
            return SPECIAL_LAT;
        return 33;
    endfunction

    // Issues one op from an idle unit and waits (bounded) for done; inputs are scrambled after acceptance.
    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input logic [4:0] r,
                          output logic [31:0] res, output logic [4:0] rdo, output int lat, output logic bsy);
        @(negedge clk);
        op = f; a = x; b = y; rd_in = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom; rd_in = 5'($urandom);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = result; rdo = rd_out; bsy = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
        n_checks++; if (rd_out !== 5'h0) begin n_fail++; $display("FAIL reset_rd_out: got %h expected 0", rd_out); end
        start = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    logic [2:0]  d_op [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] d_a  [14] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
    logic [31:0] d_b  [14] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                               32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] d_exp[14] = '{32'hFFFF_FFEB, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                               32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFB};

    task automatic test_directed();
        logic [31:0] res; logic [4:0] rdo; int lat; logic bsy; logic [4:0] r;
        for (int i = 0; i < 14; i++) begin
            r = 5'(i + 5);
            run_op(d_op[i], d_a[i], d_b[i], r, res, rdo, lat, bsy);
            n_checks++; if (res !== d_exp[i]) begin n_fail++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, d_exp[i]); end
            n_checks++; if (rdo !== r) begin n_fail++; $display("FAIL directed_rd_out[%0d]: got %0d expected %0d", i, rdo, r); end
            n_checks++; if (lat != exp_latency(d_op[i], d_a[i], d_b[i])) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, exp_latency(d_op[i], d_a[i], d_b[i])); end
            n_checks++; if (bsy !== 1'b0) begin n_fail++; $display("FAIL directed_busy_at_done[%0d]: got %b expected 0", i, bsy); end
            @(negedge clk);
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL directed_done_width[%0d]: got %b expected 0", i, done); end
            exp_last = d_exp[i]; exp_rd_last = r;
        end
    endtask

    task automatic test_random();
        logic [31:0] res, x, y, e; logic [4:0] rdo, r; logic [2:0] f; int lat; logic bsy;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom); x = $urandom; y = $urandom; r = 5'($urandom);
            case ($urandom_range(0, 7))
                0: y = 32'h0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = $urandom_range(1, 15);
                3: x = $urandom_range(0, 100);
                default: ;
            endcase
            e = ref_model(f, x, y);
            run_op(f, x, y, r, res, rdo, lat, bsy);
            n_checks++; if (res !== e) begin n_fail++; $display("FAIL random_result op=%0d a=%h b=%h: got %h expected %h", f, x, y, res, e); end
            n_checks++; if (rdo !== r) begin n_fail++; $display("FAIL random_rd_out: got %0d expected %0d", rdo, r); end
            n_checks++; if (lat != exp_latency(f, x, y)) begin n_fail++; $display("FAIL random_latency op=%0d: got %0d expected %0d", f, lat, exp_latency(f, x, y)); end
            exp_last = e; exp_rd_last = r;
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        op = 3'd5; a = 32'd1000; b = 32'd9; rd_in = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (lat == 10) begin op = 3'd0; a = 32'd3; b = 32'd4; rd_in = 5'd9; start = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        n_checks++; if (result !== 32'd111) begin n_fail++; $display("FAIL ignore_start_result: got %h expected %h", result, 32'd111); end
        n_checks++; if (rd_out !== 5'd3) begin n_fail++; $display("FAIL ignore_start_rd_out: got %0d expected 3", rd_out); end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL ignore_start_latency: got %0d expected 33", lat); end
        exp_last = 32'd111; exp_rd_last = 5'd3;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res, x1, y1, x2, y2, e1, e2; logic [4:0] rdo; int lat; logic bsy;
        x1 = $urandom; y1 = $urandom; e1 = ref_model(3'd3, x1, y1);
        x2 = $urandom; y2 = ($urandom & 32'h7FFF_FFFF) | 32'h1; e2 = ref_model(3'd6, x2, y2);
        run_op(3'd3, x1, y1, 5'd17, res, rdo, lat, bsy);
        n_checks++; if (res !== e1) begin n_fail++; $display("FAIL b2b_first_result: got %h expected %h", res, e1); end
        op = 3'd6; a = x2; b = y2; rd_in = 5'd21; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++; if (result !== e2) begin n_fail++; $display("FAIL b2b_second_result: got %h expected %h", result, e2); end
        n_checks++; if (rd_out !== 5'd21) begin n_fail++; $display("FAIL b2b_second_rd_out: got %0d expected 21", rd_out); end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
        exp_last = e2; exp_rd_last = 5'd21;
    endtask

    task automatic test_flush();
        bit seen;
        @(negedge clk);
        op = 3'd4; a = 32'd12345; b = 32'd7; rd_in = 5'd30; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        flush = 1'b1; start = 1'b1; op = 3'd5; a = 32'd9; b = 32'd0; rd_in = 5'd1;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_done: got %b expected 0", done); end
        seen = 0;
        repeat (40) begin @(negedge clk); if (done === 1'b1) seen = 1; end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_done: got %b expected 0", seen); end
        n_checks++; if (result !== exp_last) begin n_fail++; $display("FAIL flush_result_held: got %h expected %h", result, exp_last); end
        n_checks++; if (rd_out !== exp_rd_last) begin n_fail++; $display("FAIL flush_rd_held: got %0d expected %0d", rd_out, exp_rd_last); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        op = 3'd1; a = 32'hDEAD_BEEF; b = 32'h1234_5678; rd_in = 5'd12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", done); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL midreset_result: got %h expected 0", result); end
        n_checks++; if (rd_out !== 5'h0) begin n_fail++; $display("FAIL midreset_rd_out: got %0d expected 0", rd_out); end
        seen = 0;
        repeat (40) begin @(negedge clk); if (done === 1'b1) seen = 1; end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_no_done: got %b expected 0", seen); end
    endtask

    task automatic test_recovery();
        logic [31:0] res; logic [4:0] rdo; int lat; logic bsy;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, res, rdo, lat, bsy);
        n_checks++; if (res !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL recovery_result: got %h expected %h", res, 32'hFFFF_FFEB); end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL recovery_latency: got %0d expected 33", lat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_recovery();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The parameter DATA_WIDTH SHALL default to 32 and set the operand/result width; only 32 is supported.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 flush  input  1  abort current operation.
REQ-006 op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 a  input  DATA_WIDTH  operand rs1, driven from register-file RD1.
REQ-008 b  input  DATA_WIDTH  operand rs2, driven from register-file RD2.
REQ-009 rd_in  input  5  destination register index.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle result-valid pulse; drives register-file WE3.
REQ-012 result  output  DATA_WIDTH  registered result; drives register-file WD3.
REQ-013 rd_out  output  5  latched rd_in; drives register-file AD3.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, DONE; busy=1 only in CALC, done=1 only in DONE.
REQ-015 In IDLE or DONE, start=1 and flush=0 at a rising edge SHALL latch op, a, b, rd_in, clear the iteration counter, and enter CALC.
REQ-016 start while busy=1 SHALL be ignored; latched operands SHALL be unaffected by input changes after acceptance.
REQ-017 CALC SHALL perform one iteration per cycle for 32 cycles (shift-add multiply on magnitudes; restoring divide on magnitudes), then enter DONE with result registered; done SHALL be high in the cycle after the 32nd CALC edge.
REQ-018 DONE SHALL last exactly one cycle, returning to IDLE unless start is accepted (back-to-back; next done 33 cycles later).
REQ-019 MUL SHALL return product bits [31:0]; MULH signed x signed [63:32]; MULHSU signed a x unsigned b [63:32]; MULHU unsigned [63:32].
REQ-020 DIV/REM SHALL be signed, truncating toward zero; remainder sign SHALL equal dividend sign; DIVU/REMU unsigned.
REQ-021 Divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = a.
REQ-022 Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV result 0x80000000; REM result 0.
REQ-023 flush=1 at an edge SHALL return to IDLE, suppress done, hold result; flush SHALL win over a simultaneous start.
REQ-024 result and rd_out SHALL hold their last values until the next DONE.

Reset
REQ-025 rst_n=0 at an edge SHALL force IDLE, busy=0, done=0, result=0, rd_out=0, counter=0, including mid-operation; no done SHALL follow.
REQ-026 rst_n SHALL take priority over flush and start.

Configuration
REQ-027 Macro MULDIV_EARLY_EN defined: divide-by-zero and signed-overflow cases SHALL skip CALC iterations and assert done in the cycle after the accepting edge (latency 1).
REQ-028 MULDIV_EARLY_EN undefined: these cases SHALL take the full 32-iteration latency with identical results; all other ops unchanged in both builds.

Verification
REQ-029 MUL a=7, b=-3 (0xFFFFFFFD), rd_in=5 -> done after 33 cycles, result 0xFFFFFFEB, rd_out=5, busy low with done.
REQ-030 MULH/MULHU a=b=0xFFFFFFFF -> MULH 0x00000000, MULHU 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-031 DIV a=-7, b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
REQ-032 DIVU a=5, b=0 -> 0xFFFFFFFF, REMU -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; latency 1 with MULDIV_EARLY_EN, 33 without.
REQ-033 start asserted at cycle 10 of CALC with new operands -> ignored, original result delivered; start during DONE -> new op accepted, second done 33 cycles later.
REQ-034 flush at CALC cycle 15 -> IDLE, no done, result unchanged; rst_n=0 at CALC cycle 20 -> all outputs 0, no done.
